// File: rtl/set_job_dispatcher_if.sv
// set_job_dispatcher_if: job, SET-engine and result handshakes of the SET job dispatcher
// Signals: in_* job offer (valid/ready), set_* issue bus to SET (en/busy/valid/candidate),
//   res_* tagged result return (valid/ready, err), fifo_count queued-job level.
// Modports: slave = dispatcher side, master = environment (requester + SET engine).
interface set_job_dispatcher_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [23:0]              in_central;
  logic [11:0]              in_radius;
  logic [1:0]               in_mode;
  logic                     set_en;
  logic [23:0]              set_central;
  logic [11:0]              set_radius;
  logic [1:0]               set_mode;
  logic                     set_busy;
  logic                     set_valid;
  logic [7:0]               set_candidate;
  logic                     res_valid;
  logic                     res_ready;
  logic [7:0]               res_candidate;
  logic [TAG_W-1:0]         res_tag;
  logic                     res_err;
  logic [$clog2(DEPTH):0]   fifo_count;
  modport slave (
    input  in_valid, in_central, in_radius, in_mode, set_busy, set_valid, set_candidate, res_ready,
    output in_ready, set_en, set_central, set_radius, set_mode, res_valid, res_candidate, res_tag,
           res_err, fifo_count
  );
  modport master (
    output in_valid, in_central, in_radius, in_mode, set_busy, set_valid, set_candidate, res_ready,
    input  in_ready, set_en, set_central, set_radius, set_mode, res_valid, res_candidate, res_tag,
           res_err, fifo_count
  );
endinterface

// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: queues SET jobs, issues them one at a time and returns tagged results
// Ports: clk; rst (asynchronous, active-low); io (set_job_dispatcher_if.slave) carrying the
//   job input handshake, the SET en/busy/valid bus, the tagged result handshake and fifo_count.
// Option: define SET_TIMEOUT_EN to add a TIMEOUT-cycle watchdog that returns 8'hFF with res_err.
module set_job_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
`ifdef SET_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input logic clk,
  input logic rst,
  set_job_dispatcher_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } job_t;
  state_t           r_state, w_next;
  job_t             r_mem [DEPTH];
  job_t             r_issue;
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic [TAG_W-1:0] r_tag, r_res_tag;
  logic [7:0]       r_cand;
  logic             r_res_valid;
  logic             w_push, w_pop, w_cap, w_expire, w_accept;
  assign io.in_ready = r_cnt != (AW+1)'(DEPTH);
  assign w_push      = io.in_valid && io.in_ready;
  // Issue only from IDLE, so at most one job is ever outstanding at SET.
  assign w_pop       = r_state == IDLE && r_cnt != '0 && !io.set_busy;
  assign w_cap       = r_state == WAIT && io.set_valid;
  assign w_accept    = r_state == HOLD && io.res_ready;
`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;
  // A real result on the expiry cycle takes priority over the watchdog.
  assign w_expire  = r_state == WAIT && !io.set_valid && r_tmo == TW'(TIMEOUT - 1);
  assign io.res_err = r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= r_state == WAIT ? r_tmo + 1'b1 : '0;
      r_err <= w_expire ? 1'b1 : (w_accept ? 1'b0 : r_err);
    end
  end
`else
  assign w_expire   = 1'b0;
  assign io.res_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (w_cap || w_expire) ? HOLD : WAIT;
      HOLD:    w_next = w_accept ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {io.in_central, io.in_radius, io.in_mode, r_tag};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_issue     <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_res_tag   <= '0;
      r_cand      <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_res_valid <= w_next == HOLD;
      r_cnt       <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) begin
        r_wp  <= r_wp + 1'b1;
        r_tag <= r_tag + 1'b1;
      end
      if (w_pop) begin
        r_issue <= r_mem[r_rp];
        r_rp    <= r_rp + 1'b1;
      end
      if (w_cap || w_expire) begin
        r_cand    <= w_cap ? io.set_candidate : 8'hFF;
        r_res_tag <= r_issue.tag;
      end
    end
  end
  assign io.set_en        = r_state == ISSUE;
  assign io.set_central   = r_issue.central;
  assign io.set_radius    = r_issue.radius;
  assign io.set_mode      = r_issue.mode;
  assign io.res_valid     = r_res_valid;
  assign io.res_candidate = r_cand;
  assign io.res_tag       = r_res_tag;
  assign io.fifo_count    = r_cnt;
endmodule

// File: tb/tb_set_job_dispatcher.sv
// tb_set_job_dispatcher: directed stimulus with a transaction-level job/result scoreboard
module tb_set_job_dispatcher;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  typedef struct packed {
    logic [23:0]      c;
    logic [11:0]      r;
    logic [1:0]       m;
    logic [TAG_W-1:0] t;
  } job_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int lat = 3;
  bit never_valid = 1'b0;
  bit force_busy = 1'b0;
  bit tmo_exp = 1'b0;
  logic sim_busy = 1'b0;
  int got_tags[$];
  job_t q[$];
  job_t oj, pj;
  bit p_push = 1'b0;
  bit outst = 1'b0;
  int m_cnt = 0;
  logic [TAG_W-1:0] m_tag = '0;
  logic prev_en = 1'b0;
  always #5 clk = ~clk;
  set_job_dispatcher_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) b ();
  set_job_dispatcher #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
`ifdef SET_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (.clk(clk), .rst(rst), .io(b));
  assign b.set_busy = sim_busy | force_busy;
  function automatic logic [7:0] setf(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    return 8'(c[3:0]) + 8'(c[7:4]) + 8'(r[3:0]) + 8'(r[7:4]) + 8'(m) * 8'd64;
  endfunction
  function automatic job_t mk(input int i);
    job_t j;
    j.c = 24'(32'h334455 + i * 32'h010203);
    j.r = 12'(32'h234 + i * 7);
    j.m = 2'(i);
    j.t = '0;
    return j;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask
  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s: bound expired", n);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    b.in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask
  task automatic push(input job_t j);
    logic acc;
    b.in_central = j.c;
    b.in_radius  = j.r;
    b.in_mode    = j.m;
    b.in_valid   = 1'b1;
    for (int k = 0; k < 300; k++) begin
      acc = b.in_ready;
      tick();
      if (acc) return;
    end
    fail("push");
  endtask
  task automatic wait_res();
    for (int k = 0; k < 500 && !b.res_valid; k++) tick();
    if (!b.res_valid) fail("res_wait");
  endtask
  // SET engine stand-in: busy from the en pulse until a one-cycle valid strobe lat cycles later
  initial begin
    int left;
    bit act;
    job_t cj;
    act = 1'b0;
    left = 0;
    cj = '0;
    b.set_valid = 1'b0;
    b.set_candidate = '0;
    forever begin
      tick();
      if (!rst) begin
        act = 1'b0;
        sim_busy = 1'b0;
        b.set_valid = 1'b0;
      end else begin
        if (b.set_valid) begin
          b.set_valid = 1'b0;
          sim_busy = 1'b0;
        end
        if (act) begin
          if (left == 0) begin
            b.set_valid = 1'b1;
            b.set_candidate = setf(cj.c, cj.r, cj.m);
            act = 1'b0;
          end else left--;
        end
        if (b.set_en && !never_valid) begin
          act = 1'b1;
          left = lat - 1;
          sim_busy = 1'b1;
          cj.c = b.set_central;
          cj.r = b.set_radius;
          cj.m = b.set_mode;
        end
      end
    end
  end
  // Scoreboard: pushed jobs must leave in order, results must belong to the outstanding job
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      got_tags.delete();
      p_push = 1'b0;
      outst = 1'b0;
      m_cnt = 0;
      m_tag = '0;
      prev_en = 1'b0;
    end else begin
      if (p_push) begin
        q.push_back(pj);
        m_cnt++;
      end
      if (b.set_en) begin
        chk("issue_nonempty", 32'(q.size() != 0), 1);
        chk("issue_single_outstanding", 32'(outst), 0);
        if (q.size() != 0) begin
          oj = q.pop_front();
          m_cnt--;
          chk("issue_central", b.set_central, oj.c);
          chk("issue_radius", b.set_radius, oj.r);
          chk("issue_mode", b.set_mode, oj.m);
        end
        outst = 1'b1;
      end else if (outst) begin
        chk("hold_central", b.set_central, oj.c);
        chk("hold_mode", b.set_mode, oj.m);
      end
      chk("en_one_cycle", 32'(prev_en && b.set_en), 0);
      prev_en = b.set_en;
      chk("fifo_count", b.fifo_count, m_cnt);
      chk("in_ready", b.in_ready, m_cnt < DEPTH);
`ifdef SET_TIMEOUT_EN
      chk("res_err", b.res_err, b.res_valid && tmo_exp);
`else
      chk("res_err", b.res_err, 0);
`endif
      if (b.res_valid) begin
        chk("res_outstanding", 32'(outst), 1);
        chk("res_candidate", b.res_candidate, tmo_exp ? 8'hFF : setf(oj.c, oj.r, oj.m));
        chk("res_tag", b.res_tag, oj.t);
        if (b.res_ready) begin
          got_tags.push_back(int'(oj.t));
          outst = 1'b0;
          tmo_exp = 1'b0;
        end
      end
      p_push = b.in_valid && m_cnt < DEPTH;
      if (p_push) begin
        pj = '{b.in_central, b.in_radius, b.in_mode, m_tag};
        m_tag++;
      end
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    job_t j;
    int n;
    b.in_valid = 1'b0;
    b.in_central = '0;
    b.in_radius = '0;
    b.in_mode = '0;
    b.res_ready = 1'b1;
    repeat (2) tick();
    chk("rst_set_en", b.set_en, 0);
    chk("rst_set_central", b.set_central, 0);
    chk("rst_res_valid", b.res_valid, 0);
    chk("rst_res_candidate", b.res_candidate, 0);
    chk("rst_res_tag", b.res_tag, 0);
    chk("rst_fifo_count", b.fifo_count, 0);
    do_reset();
    chk("rst_in_ready", b.in_ready, 1);
    // single job: set_en exactly one cycle, two cycles after the push cycle
    lat = 10;
    push(mk(0));
    b.in_valid = 1'b0;
    chk("t1_en_cycle1", b.set_en, 0);
    tick();
    chk("t1_en_cycle2", b.set_en, 1);
    chk("t1_central", b.set_central, 24'h334455);
    tick();
    chk("t1_en_cycle3", b.set_en, 0);
    wait_res();
    chk("t1_candidate", b.res_candidate, 8'd17);
    chk("t1_tag", b.res_tag, 0);
    repeat (3) tick();
    // backpressure: SET busy, five back-to-back offers, fifth dropped
    do_reset();
    force_busy = 1'b1;
    b.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      j = mk(i);
      b.in_central = j.c;
      b.in_radius = j.r;
      b.in_mode = j.m;
      b.in_valid = 1'b1;
      tick();
    end
    b.in_valid = 1'b0;
    chk("t2_fifo_full", b.fifo_count, 4);
    chk("t2_in_ready", b.in_ready, 0);
    // result hold: res_ready low for 20 cycles blocks further issue
    force_busy = 1'b0;
    wait_res();
    j = mk(0);
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_candidate", b.res_candidate, setf(j.c, j.r, j.m));
      chk("t3_hold_tag", b.res_tag, 0);
      chk("t3_no_issue", b.set_en, 0);
      tick();
    end
    chk("t3_queued", b.fifo_count, 3);
    b.res_ready = 1'b1;
    tick();
    chk("t3_released", b.res_valid, 0);
    chk("t3_pop_cycle", b.set_en, 0);
    tick();
    chk("t3_issue_resumes", b.set_en, 1);
    for (int k = 0; k < 400 && got_tags.size() < 4; k++) tick();
    repeat (20) tick();
    chk("t2_result_count", got_tags.size(), 4);
    for (int i = 0; i < got_tags.size(); i++) chk("t2_tag_order", got_tags[i], i);
    chk("t2_drained", b.fifo_count, 0);
    // tag wrap over 20 streamed jobs, modes cycling 0..3
    do_reset();
    lat = 2;
    for (int i = 0; i < 20; i++) push(mk(i));
    b.in_valid = 1'b0;
    for (int k = 0; k < 2000 && got_tags.size() < 20; k++) tick();
    chk("t4_result_count", got_tags.size(), 20);
    for (int i = 0; i < got_tags.size(); i++) chk("t4_tag_wrap", got_tags[i], i % 16);
    // asynchronous reset while waiting on SET with three jobs queued
    do_reset();
    lat = 60;
    for (int i = 0; i < 4; i++) push(mk(i + 5));
    b.in_valid = 1'b0;
    repeat (10) tick();
    chk("t5_queued", b.fifo_count, 3);
    chk("t5_waiting", b.res_valid, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_fifo_count", b.fifo_count, 0);
    chk("t5_set_en", b.set_en, 0);
    chk("t5_set_central", b.set_central, 0);
    chk("t5_set_radius", b.set_radius, 0);
    chk("t5_set_mode", b.set_mode, 0);
    chk("t5_res_valid", b.res_valid, 0);
    chk("t5_res_tag", b.res_tag, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t5_in_ready", b.in_ready, 1);
    lat = 3;
    push(mk(9));
    b.in_valid = 1'b0;
    wait_res();
    chk("t5_first_tag", b.res_tag, 0);
    repeat (3) tick();
`ifdef SET_TIMEOUT_EN
    // watchdog: SET never answers, result appears 16 cycles into WAIT
    do_reset();
    never_valid = 1'b1;
    tmo_exp = 1'b1;
    push(mk(1));
    b.in_valid = 1'b0;
    for (int k = 0; k < 20 && !b.set_en; k++) tick();
    n = 0;
    while (!b.res_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t6_expiry_delay", n, 17);
    chk("t6_candidate", b.res_candidate, 8'hFF);
    chk("t6_err", b.res_err, 1);
    never_valid = 1'b0;
    tick();
    push(mk(2));
    b.in_valid = 1'b0;
    wait_res();
    chk("t6_next_err", b.res_err, 0);
    chk("t6_next_tag", b.res_tag, 1);
    repeat (3) tick();
`else
    n = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
